pwm_duty_ramp: RTL and testbench

Upstream duty-cycle sequencer for the PWM stage: produces the `R+1`-bit `duty` word that the PWM consumes and steps it up and down in a triangle ("breathing") profile. Updates are paced by a one-cycle `period_tick`, normally the PWM timer's done pulse, so `duty` changes once per N PWM periods. One-shot and continuous modes are supported, with start/abort control and busy/done status.

---
 rtl/pwm_duty_ramp.sv | 146 ++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: triangle ("breathing") duty-cycle sequencer for a PWM stage.
// The duty word steps up to a peak and back down to zero, one step every
// ticks_per_step period ticks, as a single pass or continuously.
module pwm_duty_ramp #(
  parameter int R        = 8,
  parameter int DIV_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                period_tick,
  input  logic                start,
  input  logic                abort,
  input  logic                continuous,
  input  logic [R:0]          step,
  input  logic [R:0]          max_duty,
  input  logic [DIV_BITS-1:0] ticks_per_step,
  output logic [R:0]          duty,
  output logic                busy,
  output logic                dir_up,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  // 100 % duty: 2^R in R+1 bits.
  localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};

  state_t              state, state_nxt;
  logic [R:0]          duty_nxt;
  logic                done_nxt;
  logic [DIV_BITS-1:0] cnt, cnt_nxt, cnt_inc;
  logic                load_cfg;

  // Configuration captured at start, already normalised (zero -> one, clamp).
  logic                cfg_cont;
  logic [R:0]          cfg_step;
  logic [R:0]          cfg_max;
  logic [DIV_BITS-1:0] cfg_tps;

  // One bit wider than duty so the peak comparison cannot wrap.
  logic [R+1:0]        sum;

  assign busy   = (state == S_UP) || (state == S_DOWN);
  assign dir_up = (state == S_UP);

  // Next-state, next-duty and divider logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave
    // it unassigned; that is what keeps this block from inferring latches.
    state_nxt = state;
    duty_nxt  = duty;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    load_cfg  = 1'b0;
    cnt_inc   = cnt + DIV_BITS'(1);
    sum       = {1'b0, duty} + {1'b0, cfg_step};

    case (state)
      S_IDLE: begin
        duty_nxt = '0;
        cnt_nxt  = '0;
        if (start) begin
          state_nxt = S_UP;
          load_cfg  = 1'b1;
        end
      end

      S_UP, S_DOWN: begin
        if (period_tick) begin
          if (cnt_inc == cfg_tps) begin
            cnt_nxt = '0;
            if (state == S_UP) begin
              if (sum >= {1'b0, cfg_max}) begin
                duty_nxt  = cfg_max;
                state_nxt = S_DOWN;
              end else begin
                duty_nxt = sum[R:0];
              end
            end else begin
              if (duty <= cfg_step) begin
                duty_nxt = '0;
                if (cfg_cont) begin
                  state_nxt = S_UP;
                end else begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
                end
              end else begin
                duty_nxt = duty - cfg_step;
              end
            end
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
        duty_nxt  = '0;
        cnt_nxt   = '0;
      end
    endcase

    // Abort overrides everything, including a start or a pass ending this cycle.
    if (abort) begin
      state_nxt = S_IDLE;
      duty_nxt  = '0;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
      load_cfg  = 1'b0;
    end
  end

  // State, duty, divider and latched configuration registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state    <= S_IDLE;
      duty     <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      cfg_cont <= 1'b0;
      cfg_step <= R'(1);
      cfg_max  <= '0;
      cfg_tps  <= DIV_BITS'(1);
    end else begin
      state <= state_nxt;
      duty  <= duty_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      if (load_cfg) begin
        cfg_cont <= continuous;
        cfg_step <= (step == '0) ? (R+1)'(1) : step;
        cfg_max  <= (max_duty > FULL) ? FULL : max_duty;
        cfg_tps  <= (ticks_per_step == '0) ? DIV_BITS'(1) : ticks_per_step;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: random stimulus compared cycle by
// cycle with a profile-list reference model, plus the directed scenarios.
module tb_pwm_duty_ramp;

  localparam int R        = 8;
  localparam int DIV_BITS = 8;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                period_tick = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                continuous = 1'b0;
  logic [R:0]          step = '0;
  logic [R:0]          max_duty = '0;
  logic [DIV_BITS-1:0] ticks_per_step = '0;
  logic [R:0]          duty;
  logic                busy, dir_up, done;

  int n_checks = 0;
  int n_errors = 0;

  pwm_duty_ramp #(.R(R), .DIV_BITS(DIV_BITS)) dut (
    .clk(clk), .reset_n(reset_n), .period_tick(period_tick), .start(start),
    .abort(abort), .continuous(continuous), .step(step), .max_duty(max_duty),
    .ticks_per_step(ticks_per_step), .duty(duty), .busy(busy),
    .dir_up(dir_up), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The whole pass is precomputed as a list of duty values; each update pops
  // the next one. Values before (and including) the peak are the rising half.
  int  q[$];
  int  n_up_left = 0;
  bit  m_busy = 0, m_up = 0, m_done = 0, m_cont = 0;
  int  m_duty = 0, m_tcnt = 0, m_step = 1, m_max = 0, m_tps = 1;
  int  m_done_cnt = 0, dut_done_cnt = 0;
  int  obs[$];
  int  last_duty = 0;

  task automatic build_pass();
    int v;
    q.delete();
    n_up_left = 0;
    v = m_step;
    while (v < m_max) begin q.push_back(v); n_up_left++; v += m_step; end
    q.push_back(m_max); n_up_left++;
    v = m_max - m_step;
    while (v > 0) begin q.push_back(v); v -= m_step; end
    q.push_back(0);
  endtask

  task automatic go_idle();
    m_busy = 0; m_up = 0; m_duty = 0; m_tcnt = 0; q.delete();
  endtask

  // Computes the expected post-edge outputs from the inputs present now.
  task automatic model_step();
    m_done = 0;
    if (!reset_n) begin
      go_idle();
    end else if (abort) begin
      go_idle();
    end else if (!m_busy) begin
      m_duty = 0;
      if (start) begin
        m_cont = continuous;
        m_step = (step == 0) ? 1 : int'(step);
        m_max  = (max_duty > 256) ? 256 : int'(max_duty);
        m_tps  = (ticks_per_step == 0) ? 1 : int'(ticks_per_step);
        build_pass();
        m_busy = 1; m_up = 1; m_tcnt = 0;
      end
    end else if (period_tick) begin
      m_tcnt++;
      if (m_tcnt == m_tps) begin
        m_tcnt = 0;
        m_duty = q.pop_front();
        if (n_up_left > 0) n_up_left--;
        if (q.size() == 0) begin
          if (m_cont) begin
            build_pass(); m_up = 1;
          end else begin
            m_busy = 0; m_up = 0; m_done = 1; m_done_cnt++;
          end
        end else begin
          m_up = (n_up_left > 0);
        end
      end
    end
  endtask

  // One clock: model, edge, sample 1 ns later, release pulses.
  task automatic do_cycle();
    model_step();
    @(posedge clk);
    #1;
    check("duty",   32'(duty),   32'(m_duty));
    check("busy",   32'(busy),   32'(m_busy));
    check("dir_up", 32'(dir_up), 32'(m_up));
    check("done",   32'(done),   32'(m_done));
    if (done === 1'b1) dut_done_cnt++;
    if (int'(duty) != last_duty) begin obs.push_back(int'(duty)); last_duty = int'(duty); end
    start = 0;
    abort = 0;
  endtask

  // Starts a ramp and runs it with random ticks, stray starts, config churn and aborts.
  task automatic run_ramp(input bit cont, input int st, input int mx, input int tp,
                          input int cycles, input int tick_pct, input int start_pct,
                          input int abort_pct);
    continuous = cont;
    step = (R+1)'(st);
    max_duty = (R+1)'(mx);
    ticks_per_step = DIV_BITS'(tp);
    start = 1;
    period_tick = 1'($urandom_range(0, 1));
    do_cycle();
    for (int i = 0; i < cycles; i++) begin
      period_tick = ($urandom_range(0, 99) < tick_pct);
      if ($urandom_range(0, 99) < start_pct) start = 1;
      if ($urandom_range(0, 999) < abort_pct) abort = 1;
      if ($urandom_range(0, 99) < 10) begin
        continuous = 1'($urandom);
        step = (R+1)'($urandom);
        max_duty = (R+1)'($urandom);
        ticks_per_step = DIV_BITS'($urandom);
      end
      do_cycle();
    end
    period_tick = 0;
  endtask

  task automatic check_seq(input string tag, input int exp[]);
    check({tag, "_len"}, 32'(obs.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      check(tag, 32'(obs[i]), 32'(exp[i]));
  endtask

  task automatic clear_obs();
    obs.delete();
    last_duty = int'(duty);
    m_done_cnt = 0;
    dut_done_cnt = 0;
  endtask

  initial begin
    // Reset state.
    repeat (2) do_cycle();
    reset_n = 1;
    do_cycle();

    // One-shot, step 64 up to full scale, every tick counted.
    clear_obs();
    run_ramp(0, 64, 256, 1, 14, 100, 0, 0);
    check_seq("seq_oneshot", '{64, 128, 192, 256, 192, 128, 64, 0});
    check("done_cnt_oneshot", 32'(dut_done_cnt), 32'(1));

    // Clamped peak and a step that does not divide it.
    clear_obs();
    run_ramp(0, 100, 300, 1, 10, 100, 0, 0);
    check_seq("seq_clamp", '{100, 200, 256, 156, 56, 0});

    // Divider of 3 with sparse ticks, then divider 0 and step 0 (both mean 1).
    clear_obs();
    run_ramp(0, 1, 10, 3, 200, 50, 0, 0);
    check("done_cnt_div3", 32'(dut_done_cnt), 32'(m_done_cnt));
    clear_obs();
    run_ramp(0, 0, 5, 0, 14, 100, 0, 0);
    check_seq("seq_step0", '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0});

    // Zero peak: two updates, both at zero, then done.
    clear_obs();
    run_ramp(0, 50, 0, 1, 5, 100, 0, 0);
    check("done_cnt_max0", 32'(dut_done_cnt), 32'(1));

    // Continuous with stray starts while busy, ended by abort.
    clear_obs();
    run_ramp(1, 128, 256, 1, 8, 100, 30, 0);
    check_seq("seq_cont", '{128, 256, 128, 0, 128, 256, 128, 0});
    abort = 1;
    do_cycle();
    check("done_cnt_cont", 32'(dut_done_cnt), 32'(0));

    // Abort mid-UP, then abort and start together from idle.
    run_ramp(0, 10, 200, 1, 5, 100, 0, 0);
    abort = 1; period_tick = 1;
    do_cycle();
    abort = 1; start = 1;
    do_cycle();
    period_tick = 0;
    repeat (3) do_cycle();

    // Reset held 3 cycles mid-ramp; later ticks must not move duty.
    run_ramp(0, 20, 256, 1, 6, 100, 0, 0);
    reset_n = 0; period_tick = 1;
    repeat (3) do_cycle();
    reset_n = 1;
    repeat (5) do_cycle();
    period_tick = 0;

    // Random configurations, with occasional aborts and stray starts.
    for (int t = 0; t < 25; t++) begin
      run_ramp(1'($urandom), $urandom_range(0, 300), $urandom_range(0, 400),
               $urandom_range(0, 4), $urandom_range(50, 400),
               $urandom_range(30, 100), 3, 4);
      if ($urandom_range(0, 3) == 0) begin
        reset_n = 0;
        do_cycle();
        reset_n = 1;
      end
    end
    abort = 1;
    do_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
